reg_writeback: RTL and testbench

Writer side of the register-file write port: arbitrates single-cycle results from the MEM/WB pipeline register and long-latency results (mult/div, late loads) into one registered `reg_write`/`rd`/`write_data` stream. Long-latency results are buffered in a small in-order queue and drained in cycles where the pipeline does not write. The block also supplies forwarding lookups for decode, so values not yet written to the register file are visible, and it raises a stall request when the queue cannot drain.

---
 rtl/reg_writeback_if.sv | 69 ++++++
 rtl/reg_writeback.sv | 208 ++++++++++++++++++++
 tb/tb_reg_writeback.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_writeback_if.sv
// -----------------------------------------------------------------------------
// reg_writeback_if
// Bundles the register-file writeback signals: the MEM/WB pipe slot, the
// long-latency result handshake, the registered register-file write port,
// the decode forwarding lookups and the stall/occupancy status.
//
// Modports
//   master : upstream/decode side (drives pipe_*, lng_valid/rd/data, fwd_rs/rt)
//   slave  : the writeback block (drives lng_ready, reg_write/rd/write_data,
//            fwd_*_hit/data, stall_req, pend_count)
//
// Parameter
//   DEPTH  : long-latency queue depth; sizes pend_count
// -----------------------------------------------------------------------------
interface reg_writeback_if #(
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  // MEM/WB pipeline slot
  logic             pipe_valid;
  logic             pipe_we;
  logic [4:0]       pipe_rd;
  logic [31:0]      pipe_data;

  // Long-latency result handshake
  logic             lng_valid;
  logic             lng_ready;
  logic [4:0]       lng_rd;
  logic [31:0]      lng_data;

  // Register-file write port
  logic             reg_write;
  logic [4:0]       rd;
  logic [31:0]      write_data;

  // Decode forwarding lookups
  logic [4:0]       fwd_rs;
  logic [4:0]       fwd_rt;
  logic             fwd_rs_hit;
  logic             fwd_rt_hit;
  logic [31:0]      fwd_rs_data;
  logic [31:0]      fwd_rt_data;

  // Status
  logic             stall_req;
  logic [CNT_W-1:0] pend_count;

  modport master (
    output pipe_valid, pipe_we, pipe_rd, pipe_data,
    output lng_valid, lng_rd, lng_data,
    input  lng_ready,
    input  reg_write, rd, write_data,
    output fwd_rs, fwd_rt,
    input  fwd_rs_hit, fwd_rt_hit, fwd_rs_data, fwd_rt_data,
    input  stall_req, pend_count
  );

  modport slave (
    input  pipe_valid, pipe_we, pipe_rd, pipe_data,
    input  lng_valid, lng_rd, lng_data,
    output lng_ready,
    output reg_write, rd, write_data,
    input  fwd_rs, fwd_rt,
    output fwd_rs_hit, fwd_rt_hit, fwd_rs_data, fwd_rt_data,
    output stall_req, pend_count
  );

endinterface

// File: rtl/reg_writeback.sv
// -----------------------------------------------------------------------------
// reg_writeback
// Writer side of the register-file write port. Single-cycle results from the
// MEM/WB register always win; long-latency results are held in a small
// in-order queue and drained in cycles where the pipe does not write. Pending
// values are visible to decode through two forwarding lookups, and a stall
// request is raised when the queue is full or has been starved too long.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   wb (slave) : pipe slot, long-latency handshake, register-file write port,
//                forwarding lookups, stall_req, pend_count
//
// Parameters
//   DEPTH      : queue entries (power of two, >= 2)
//   STARVE_MAX : consecutive lost arbitrations before stall_req
// -----------------------------------------------------------------------------
module reg_writeback #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst,
  reg_writeback_if.slave wb
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SC_W  = $clog2(STARVE_MAX + 1);

  // Queue storage and control
  logic [4:0]       q_rd   [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [DEPTH-1:0] q_live;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic [SC_W-1:0]  starve_q;

  // Registered write port
  logic             reg_write_q;
  logic [4:0]       rd_q;
  logic [31:0]      write_data_q;

  // Per-cycle decisions
  logic             pipe_w_c;
  logic             full_c;
  logic             empty_c;
  logic             ready_c;
  logic             push_c;
  logic             pop_c;

  // Forwarding intermediates
  logic             q_rs_hit;
  logic             q_rt_hit;
  logic [31:0]      q_rs_data;
  logic [31:0]      q_rt_data;
  logic [PTR_W-1:0] fwd_idx;
  logic [32:0]      rs_pick;
  logic [32:0]      rt_pick;

  // Arbitration and handshake decode
  always_comb begin
    pipe_w_c = wb.pipe_valid & wb.pipe_we & (wb.pipe_rd != 5'd0);
    full_c   = (count_q == CNT_W'(DEPTH));
    empty_c  = (count_q == '0);
    // Ready only looks at occupancy: a same-cycle pop never frees a slot.
    ready_c  = ~rst & ~full_c;
    // Writes to r0 are accepted on the handshake but never enqueued.
    push_c   = wb.lng_valid & ready_c & (wb.lng_rd != 5'd0);
    pop_c    = ~pipe_w_c & ~empty_c;
  end

  // Payload storage; only meaningful under the live bit / occupancy
  always_ff @(posedge clk) begin
    if (push_c) begin
      q_rd[tail_q]   <= wb.lng_rd;
      q_data[tail_q] <= wb.lng_data;
    end
  end

  // Queue control, starvation counter and registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      q_live       <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      reg_write_q  <= 1'b0;
      rd_q         <= 5'd0;
      write_data_q <= 32'd0;
    end else begin
      // The pipe instruction is younger than anything queued: kill older
      // writes to the same register so they cannot overwrite its value.
      if (pipe_w_c) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (q_rd[i] == wb.pipe_rd) begin
            q_live[i] <= 1'b0;
          end
        end
      end

      // A same-cycle push is younger than the pipe write, so it stays live.
      if (push_c) begin
        q_live[tail_q] <= 1'b1;
        tail_q         <= tail_q + PTR_W'(1);
      end

      if (pop_c) begin
        head_q <= head_q + PTR_W'(1);
      end

      count_q <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);

      if (pop_c || empty_c) begin
        starve_q <= '0;
      end else if (pipe_w_c && (starve_q < SC_W'(STARVE_MAX))) begin
        starve_q <= starve_q + SC_W'(1);
      end

      // A cancelled head still consumes its pop cycle but writes nothing.
      if (pipe_w_c) begin
        reg_write_q  <= 1'b1;
        rd_q         <= wb.pipe_rd;
        write_data_q <= wb.pipe_data;
      end else if (pop_c && q_live[head_q]) begin
        reg_write_q  <= 1'b1;
        rd_q         <= q_rd[head_q];
        write_data_q <= q_data[head_q];
      end else begin
        reg_write_q  <= 1'b0;
        rd_q         <= 5'd0;
        write_data_q <= 32'd0;
      end
    end
  end

  // Youngest live occupied queue entry per forwarding port
  always_comb begin
    q_rs_hit  = 1'b0;
    q_rt_hit  = 1'b0;
    q_rs_data = 32'd0;
    q_rt_data = 32'd0;
    fwd_idx   = '0;
    // Walk oldest to youngest so a later match overrides an earlier one.
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && q_live[fwd_idx]) begin
        if (q_rd[fwd_idx] == wb.fwd_rs) begin
          q_rs_hit  = 1'b1;
          q_rs_data = q_data[fwd_idx];
        end
        if (q_rd[fwd_idx] == wb.fwd_rt) begin
          q_rt_hit  = 1'b1;
          q_rt_data = q_data[fwd_idx];
        end
      end
    end
  end

  // Priority: pipe input, then queue, then output register; r0 never hits.
  function automatic logic [32:0] fwd_pick(
    input logic [4:0]  src,
    input logic        p_w,
    input logic [4:0]  p_rd,
    input logic [31:0] p_data,
    input logic        q_hit,
    input logic [31:0] q_val,
    input logic        o_w,
    input logic [4:0]  o_rd,
    input logic [31:0] o_data
  );
    logic [32:0] res;
    res = 33'd0;
    if (src != 5'd0) begin
      if (p_w && (p_rd == src)) begin
        res = {1'b1, p_data};
      end else if (q_hit) begin
        res = {1'b1, q_val};
      end else if (o_w && (o_rd == src)) begin
        res = {1'b1, o_data};
      end
    end
    return res;
  endfunction

  always_comb begin
    rs_pick = fwd_pick(wb.fwd_rs, pipe_w_c, wb.pipe_rd, wb.pipe_data,
                       q_rs_hit, q_rs_data, reg_write_q, rd_q, write_data_q);
    rt_pick = fwd_pick(wb.fwd_rt, pipe_w_c, wb.pipe_rd, wb.pipe_data,
                       q_rt_hit, q_rt_data, reg_write_q, rd_q, write_data_q);
  end

  assign wb.lng_ready   = ready_c;
  assign wb.reg_write   = reg_write_q;
  assign wb.rd          = rd_q;
  assign wb.write_data  = write_data_q;
  assign wb.fwd_rs_hit  = rs_pick[32];
  assign wb.fwd_rs_data = rs_pick[31:0];
  assign wb.fwd_rt_hit  = rt_pick[32];
  assign wb.fwd_rt_data = rt_pick[31:0];
  // Full, or the head has lost arbitration STARVE_MAX-1 times in a row.
  assign wb.stall_req   = full_c | (starve_q >= SC_W'(STARVE_MAX - 1));
  assign wb.pend_count  = count_q;

endmodule

// File: tb/tb_reg_writeback.sv
// -----------------------------------------------------------------------------
// tb_reg_writeback
// Directed bench for reg_writeback (DEPTH=2, STARVE_MAX=4): reset, pipe
// passthrough, queue drain/backpressure, WAW cancel, forwarding priority,
// starvation stall and reset mid-operation.
// -----------------------------------------------------------------------------
module tb_reg_writeback;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  reg_writeback_if #(.DEPTH(2)) wb ();

  reg_writeback #(
    .DEPTH      (2),
    .STARVE_MAX (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 2 units later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_pipe(input logic v, input logic we, input logic [4:0] r, input logic [31:0] d);
    wb.pipe_valid = v;
    wb.pipe_we    = we;
    wb.pipe_rd    = r;
    wb.pipe_data  = d;
  endtask

  task automatic set_lng(input logic v, input logic [4:0] r, input logic [31:0] d);
    wb.lng_valid = v;
    wb.lng_rd    = r;
    wb.lng_data  = d;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    set_pipe(1'b0, 1'b0, 5'd0, 32'd0);
    set_lng(1'b1, 5'd0, 32'h55);
    wb.fwd_rs = 5'd0;
    wb.fwd_rt = 5'd0;

    // Reset held two cycles with lng_valid asserted
    tick();
    tick();
    chk("rst_reg_write", 32'(wb.reg_write), 32'd0);
    chk("rst_rd", 32'(wb.rd), 32'd0);
    chk("rst_write_data", wb.write_data, 32'd0);
    chk("rst_lng_ready", 32'(wb.lng_ready), 32'd0);
    chk("rst_pend_count", 32'(wb.pend_count), 32'd0);
    chk("rst_stall_req", 32'(wb.stall_req), 32'd0);
    chk("rst_fwd_rs_hit", 32'(wb.fwd_rs_hit), 32'd0);

    // First cycle after reset: ready, and an r0 transfer is dropped
    rst = 1'b0;
    #1;
    chk("post_rst_lng_ready", 32'(wb.lng_ready), 32'd1);
    tick();
    set_lng(1'b0, 5'd0, 32'd0);
    chk("r0_push_pend", 32'(wb.pend_count), 32'd0);
    chk("post_rst_no_write", 32'(wb.reg_write), 32'd0);

    // Pipe passthrough
    set_pipe(1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    chk("pass_reg_write", 32'(wb.reg_write), 32'd1);
    chk("pass_rd", 32'(wb.rd), 32'd5);
    chk("pass_data", wb.write_data, 32'hDEADBEEF);
    set_pipe(1'b1, 1'b1, 5'd0, 32'h1234);
    tick();
    chk("pass_rd0_no_write", 32'(wb.reg_write), 32'd0);
    set_pipe(1'b1, 1'b0, 5'd6, 32'h5678);
    tick();
    chk("pass_we0_no_write", 32'(wb.reg_write), 32'd0);

    // Queue fill under continuous pipe writes, then drain in order
    set_pipe(1'b1, 1'b1, 5'd20, 32'hA0);
    set_lng(1'b1, 5'd8, 32'h11);
    #1;
    chk("q_ready_empty", 32'(wb.lng_ready), 32'd1);
    tick();
    chk("q_pipe20_rd", 32'(wb.rd), 32'd20);
    chk("q_pend1", 32'(wb.pend_count), 32'd1);
    set_pipe(1'b1, 1'b1, 5'd21, 32'hA1);
    set_lng(1'b1, 5'd9, 32'h22);
    tick();
    chk("q_pipe21_rd", 32'(wb.rd), 32'd21);
    chk("q_pipe21_data", wb.write_data, 32'hA1);
    chk("q_full_pend", 32'(wb.pend_count), 32'd2);
    chk("q_full_ready", 32'(wb.lng_ready), 32'd0);
    chk("q_full_stall", 32'(wb.stall_req), 32'd1);
    set_lng(1'b0, 5'd0, 32'd0);
    set_pipe(1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    chk("drain0_reg_write", 32'(wb.reg_write), 32'd1);
    chk("drain0_rd", 32'(wb.rd), 32'd8);
    chk("drain0_data", wb.write_data, 32'h11);
    chk("drain0_pend", 32'(wb.pend_count), 32'd1);
    chk("drain0_stall", 32'(wb.stall_req), 32'd0);
    chk("drain0_ready", 32'(wb.lng_ready), 32'd1);
    tick();
    chk("drain1_rd", 32'(wb.rd), 32'd9);
    chk("drain1_data", wb.write_data, 32'h22);
    chk("drain1_pend", 32'(wb.pend_count), 32'd0);
    tick();
    chk("drain_idle", 32'(wb.reg_write), 32'd0);

    // WAW cancel
    set_lng(1'b1, 5'd7, 32'hAA);
    tick();
    set_lng(1'b0, 5'd0, 32'd0);
    chk("waw_pend1", 32'(wb.pend_count), 32'd1);
    chk("waw_no_write_yet", 32'(wb.reg_write), 32'd0);
    set_pipe(1'b1, 1'b1, 5'd7, 32'hBB);
    tick();
    chk("waw_pipe_rd", 32'(wb.rd), 32'd7);
    chk("waw_pipe_data", wb.write_data, 32'hBB);
    chk("waw_pend_still1", 32'(wb.pend_count), 32'd1);
    set_pipe(1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    chk("waw_cancel_no_write", 32'(wb.reg_write), 32'd0);
    chk("waw_pend0", 32'(wb.pend_count), 32'd0);

    // Forwarding priority: simultaneous push (3,1) and pipe write r3=2
    set_lng(1'b1, 5'd3, 32'h1);
    set_pipe(1'b1, 1'b1, 5'd3, 32'h2);
    tick();
    set_lng(1'b0, 5'd0, 32'd0);
    chk("fwd_setup_outreg", wb.write_data, 32'h2);
    chk("fwd_setup_pend", 32'(wb.pend_count), 32'd1);
    set_pipe(1'b1, 1'b1, 5'd3, 32'h3);
    wb.fwd_rs = 5'd3;
    #1;
    chk("fwd_pipe_hit", 32'(wb.fwd_rs_hit), 32'd1);
    chk("fwd_pipe_data", wb.fwd_rs_data, 32'h3);
    set_pipe(1'b0, 1'b0, 5'd0, 32'd0);
    wb.fwd_rt = 5'd3;
    #1;
    chk("fwd_queue_hit", 32'(wb.fwd_rs_hit), 32'd1);
    chk("fwd_queue_data", wb.fwd_rs_data, 32'h1);
    chk("fwd_rt_queue_data", wb.fwd_rt_data, 32'h1);
    wb.fwd_rs = 5'd0;
    #1;
    chk("fwd_r0_hit", 32'(wb.fwd_rs_hit), 32'd0);
    chk("fwd_r0_data", wb.fwd_rs_data, 32'd0);
    wb.fwd_rs = 5'd3;
    wb.fwd_rt = 5'd12;
    tick();
    chk("fwd_pop_rd", 32'(wb.rd), 32'd3);
    chk("fwd_pop_data", wb.write_data, 32'h1);
    chk("fwd_outreg_hit", 32'(wb.fwd_rs_hit), 32'd1);
    chk("fwd_outreg_data", wb.fwd_rs_data, 32'h1);
    chk("fwd_miss_hit", 32'(wb.fwd_rt_hit), 32'd0);
    chk("fwd_miss_data", wb.fwd_rt_data, 32'd0);
    tick();
    chk("fwd_idle_miss", 32'(wb.fwd_rs_hit), 32'd0);
    wb.fwd_rs = 5'd0;
    wb.fwd_rt = 5'd0;

    // Starvation: one entry, pipe writes every cycle
    set_lng(1'b1, 5'd12, 32'hC0);
    set_pipe(1'b1, 1'b1, 5'd13, 32'h1);
    tick();
    set_lng(1'b0, 5'd0, 32'd0);
    chk("starve_pend", 32'(wb.pend_count), 32'd1);
    chk("starve_lost0", 32'(wb.stall_req), 32'd0);
    tick();
    chk("starve_lost1", 32'(wb.stall_req), 32'd0);
    tick();
    chk("starve_lost2", 32'(wb.stall_req), 32'd0);
    tick();
    chk("starve_lost3", 32'(wb.stall_req), 32'd1);
    set_pipe(1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    chk("starve_pop_rd", 32'(wb.rd), 32'd12);
    chk("starve_pop_data", wb.write_data, 32'hC0);
    chk("starve_stall_fall", 32'(wb.stall_req), 32'd0);
    chk("starve_pend0", 32'(wb.pend_count), 32'd0);

    // Reset mid-operation discards the queue and the in-flight write
    set_lng(1'b1, 5'd14, 32'hEE);
    set_pipe(1'b1, 1'b1, 5'd15, 32'hFF);
    tick();
    set_lng(1'b0, 5'd0, 32'd0);
    set_pipe(1'b0, 1'b0, 5'd0, 32'd0);
    chk("mid_pend_before", 32'(wb.pend_count), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_reg_write", 32'(wb.reg_write), 32'd0);
    chk("mid_rst_pend", 32'(wb.pend_count), 32'd0);
    rst = 1'b0;
    tick();
    chk("mid_no_stale_write", 32'(wb.reg_write), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
